// File: rtl/lpc_axi_pkg.sv
// rtl/lpc_axi_pkg.sv - shared LPC stream geometry for lpc_frame_packer and lpc_decoder
package lpc_axi_pkg;
  localparam int LPC_IN_W        = 16;
  localparam int LPC_LANES       = 5;
  localparam int LPC_OUT_W       = LPC_IN_W * LPC_LANES;
  localparam int LPC_FRAME_WORDS = 1920;
  localparam int LPC_LANE_IDX_W  = 3;
  localparam int LPC_WORD_CNT_W  = 11;

  typedef logic [LPC_LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [LPC_WORD_CNT_W-1:0] word_cnt_t;
endpackage

// File: rtl/lpc_frame_packer_if.sv
// rtl/lpc_frame_packer_if.sv - sample input stream and packed output stream of lpc_frame_packer
interface lpc_frame_packer_if;
  import lpc_axi_pkg::*;

  logic [LPC_IN_W-1:0]  S_DATA;
  logic                 S_VALID;
  logic                 S_READY;
  logic                 S_LAST;
  logic [LPC_OUT_W-1:0] TDATA;
  logic                 TVALID;
  logic                 TREADY;
  logic                 TLAST;
  logic                 TUSER;

  modport slave (
    input  S_DATA, S_VALID, S_LAST, TREADY,
    output S_READY, TDATA, TVALID, TLAST, TUSER
  );

  modport master (
    output S_DATA, S_VALID, S_LAST, TREADY,
    input  S_READY, TDATA, TVALID, TLAST, TUSER
  );
endinterface

// File: rtl/lpc_lane_accum.sv
// rtl/lpc_lane_accum.sv - lane index, partial-word accumulator and zero-padded word view
module lpc_lane_accum
  import lpc_axi_pkg::*;
#(
  parameter int IN_W  = LPC_IN_W,
  parameter int LANES = LPC_LANES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_accept,
  input  logic [IN_W-1:0]       i_data,
  input  logic                  i_last,
  output logic                  o_closing,
  output logic [IN_W*LANES-1:0] o_word
);
  localparam int        OUT_W     = IN_W * LANES;
  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

  lane_idx_t        r_lane;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_word;

  assign o_closing = (r_lane == LAST_LANE) || i_last;
  assign o_word    = w_word;

  // Lanes above the current index are zero, which gives the early-close padding.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(r_lane)) begin
        w_word[k*IN_W +: IN_W] = r_acc[k*IN_W +: IN_W];
      end else if (k == int'(r_lane)) begin
        w_word[k*IN_W +: IN_W] = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (i_accept) begin
      if (o_closing) begin
        r_lane <= '0;
        r_acc  <= '0;
      end else begin
        r_lane <= r_lane + lane_idx_t'(1);
        r_acc  <= w_word;
      end
    end
  end
endmodule

// File: rtl/lpc_frame_packer.sv
// rtl/lpc_frame_packer.sv - packs 16-bit LPC samples into 80-bit framed stream words
// Optional frame counter output FRAME_CNT when LPC_PACK_FRAME_CNT_EN is defined.
module lpc_frame_packer
  import lpc_axi_pkg::*;
#(
  parameter int IN_W        = LPC_IN_W,
  parameter int LANES       = LPC_LANES,
  parameter int FRAME_WORDS = LPC_FRAME_WORDS
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      EN,
  lpc_frame_packer_if.slave         bus,
`ifdef LPC_PACK_FRAME_CNT_EN
  output logic [15:0]               FRAME_CNT,
`endif
  output logic [LPC_WORD_CNT_W-1:0] WORD_CNT
);
  localparam int        OUT_W    = IN_W * LANES;
  localparam word_cnt_t LAST_IDX = word_cnt_t'(FRAME_WORDS - 1);

  logic             w_closing;
  logic             w_ready;
  logic             w_accept;
  logic             w_commit;
  logic             w_last;
  logic [OUT_W-1:0] w_word;

  logic [OUT_W-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_tuser;
  word_cnt_t        r_word_cnt;
  word_cnt_t        r_next_idx;
  logic             r_first;

  lpc_lane_accum #(
    .IN_W  (IN_W),
    .LANES (LANES)
  ) u_accum (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_accept  (w_accept),
    .i_data    (bus.S_DATA),
    .i_last    (bus.S_LAST),
    .o_closing (w_closing),
    .o_word    (w_word)
  );

  // Only a closing sample needs the output register free; partial lanes never stall.
  assign w_ready  = EN && !(w_closing && r_tvalid && !bus.TREADY);
  assign w_accept = bus.S_VALID && w_ready;
  assign w_commit = w_accept && w_closing;
  assign w_last   = bus.S_LAST || (r_next_idx == LAST_IDX);

  assign bus.S_READY = w_ready;
  assign bus.TDATA   = r_tdata;
  assign bus.TVALID  = r_tvalid;
  assign bus.TLAST   = r_tlast;
  assign bus.TUSER   = r_tuser;
  assign WORD_CNT    = r_word_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_word_cnt <= '0;
      r_next_idx <= '0;
      r_first    <= 1'b1;
    end else if (w_commit) begin
      r_tdata    <= w_word;
      r_tvalid   <= 1'b1;
      r_tlast    <= w_last;
      r_tuser    <= r_first;
      r_word_cnt <= r_next_idx;
      r_first    <= w_last;
      r_next_idx <= w_last ? '0 : r_next_idx + word_cnt_t'(1);
    end else if (bus.TREADY) begin
      r_tvalid   <= 1'b0;
    end
  end

`ifdef LPC_PACK_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  assign FRAME_CNT = r_frame_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_frame_cnt <= '0;
    end else if (r_tvalid && bus.TREADY && r_tlast) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/lpc_frame_packer.md
Name: lpc_frame_packer

Overview:
- Upstream stage of lpc_decoder.
- Packs a stream of 16-bit LPC encoder words into 80-bit AXI-Stream words (5 lanes per word) on the TDATA/TVALID/TREADY/TLAST/TUSER interface that lpc_decoder consumes.
- Marks each frame boundary: TLAST on the last word of a frame, TUSER on the first.
- Closes a partial word early, zero-padded, when the source signals end of frame.

Parameters:
- IN_W, 16, width of one input lane.
- LANES, 5, lanes per output word; TDATA width = IN_W*LANES (localparam OUT_W).
- FRAME_WORDS, 1920, output words per frame before TLAST is forced.

Ports:
- ACLK  input  1  clock; all logic on posedge.
- ARESET  input  1  reset, synchronous, active-high.
- EN  input  1  accept enable; gates S_READY only.
- S_DATA  input  IN_W  input sample.
- S_VALID  input  1  input valid.
- S_READY  output  1  input ready.
- S_LAST  input  1  last sample of frame; closes the current word.
- TDATA  output  OUT_W  packed word; lane k at bits [k*IN_W +: IN_W].
- TVALID  output  1  output valid.
- TREADY  input  1  downstream ready.
- TLAST  output  1  last word of frame.
- TUSER  output  1  first word of frame.
- WORD_CNT  output  11  index of the word currently in TDATA within its frame.

Behaviour:
- Reset (ARESET=1 at posedge):
  - TDATA=0, TVALID=0, TLAST=0, TUSER=0, WORD_CNT=0.
  - Lane index=0, accumulator=0, first-word flag=1.
  - Any partial word is discarded. Reset mid-frame drops the word in flight with no TLAST.
- Input handshake:
  - A sample is accepted when S_VALID && S_READY.
  - S_READY = EN && !(closing && TVALID && !TREADY).
  - closing = (lane==LANES-1) || S_LAST.
  - S_READY is combinational from TVALID/TREADY/state. It never depends on S_VALID.
- Accumulation:
  - An accepted sample writes lane[lane_idx], then lane_idx increments.
  - First accepted sample goes to bits [15:0].
- Commit (on accepting a sample with closing=1):
  - Next cycle: TDATA = accumulator with the new lane, upper unfilled lanes forced to 0; TVALID=1.
  - Lane index returns to 0; accumulator is cleared.
  - Latency: sample-to-TVALID is 1 cycle.
- Output register:
  - Holds TDATA/TLAST/TUSER/WORD_CNT stable while TVALID && !TREADY.
  - TVALID drops the cycle after the handshake unless a new commit happens in the same cycle. Back-to-back words are allowed, so a commit with TREADY=1 sustains TVALID=1.
- Frame rules:
  - TLAST=1 if the committed word was closed by S_LAST, or if WORD_CNT==FRAME_WORDS-1.
  - TUSER=1 when the first-word flag is set. The flag clears on commit and sets again after a committed word with TLAST.
  - WORD_CNT increments per commit and returns to 0 after a TLAST word.
- EN=0:
  - S_READY=0 and the accumulator holds.
  - A committed word still drains normally.
- Boundary cases:
  - S_LAST on lane 0: word contains one sample plus four zero lanes, TLAST=1.
  - S_LAST on lane LANES-1 behaves as a normal full commit with TLAST=1.
  - S_LAST coinciding with the FRAME_WORDS-1 word gives a single TLAST.
  - If closing stalls because the output is full, the sample is not accepted; S_VALID must hold (AXI rule).

Optional Feature:
- Macro: LPC_PACK_FRAME_CNT_EN.
- Defined: adds output FRAME_CNT[15:0], reset 0. It increments on each TVALID && TREADY && TLAST handshake and wraps 0xFFFF→0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package lpc_axi_pkg holds:
  - LPC_IN_W=16, LPC_LANES=5, LPC_OUT_W=80, LPC_FRAME_WORDS=1920.
  - Lane-index width (3) and WORD_CNT width (11).
  - lpc_decoder uses the same package.
- One natural sub-module, lpc_lane_accum: lane index, accumulator, zero-pad, closing flag.
- Top level: handshake, output register, frame counters.

Test Plan:
- Reset then 10 samples 0x0001..0x000A, TREADY=1 → two words:
  - 0x0005_0004_0003_0002_0001 with TUSER=1, TLAST=0.
  - 0x000A_0009_0008_0007_0006 with TUSER=0.
  - Each TVALID one cycle after its 5th sample.
- 3 samples 0xAAAA,0xBBBB,0xCCCC, S_LAST on the third → TDATA=0x0000_0000_CCCC_BBBB_AAAA, TLAST=1. The next word has TUSER=1.
- Continuous stream of 9600 samples → TLAST on word index 1919 only, WORD_CNT wraps to 0, next word TUSER=1.
- TREADY=0 for 12 cycles with a word pending → TDATA stable, S_READY=0 once lane==4, no data lost; full sequence matches after release.
- EN=0 after 2 accepted samples for 5 cycles, then EN=1 → no samples taken while disabled; word completes correctly after resume.
- Reset asserted after 3 samples, then 5 fresh samples → only the fresh word appears, with TUSER=1. With LPC_PACK_FRAME_CNT_EN defined, FRAME_CNT=0 after reset and 1 after the first TLAST handshake.
